col_framer: RTL
===============

# col_framer

Upstream framing stage for the L-reader FSM. Takes a serial bit stream with a per-bit valid qualifier and a start-of-frame marker, assembles 3-bit column symbols MSB-first, and presents them as `bits[2:0]` with a one-cycle `bits_valid` strobe. Emits the `restart` pulse that resynchronises the reader at each new character frame, and flags frames that overrun the column budget.

## Interface
Parameters:
- `MAX_COLS`, default 8: maximum columns per frame; column `MAX_COLS+1` onward is an overrun.
- `CNT_W`, default 4: width of `col_count`; must satisfy 2^CNT_W > `MAX_COLS`.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  synchronous reset, active-high.
- `sin`  input  1  serial data bit; sampled only when `sin_valid`=1.
- `sin_valid`  input  1  qualifies `sin` this cycle.
- `sync`  input  1  start-of-frame; only meaningful with `sin_valid`=1; marks `sin` as bit 2 (MSB) of the frame's first column.
- `bits`  output  3  last completed column, `bits[2]` = first bit received; holds between strobes.
- `bits_valid`  output  1  high for exactly one cycle per completed column.
- `restart`  output  1  high with `bits_valid` on the first column of a frame only.
- `col_count`  output  CNT_W  columns emitted in the current frame, saturating at `MAX_COLS+1`.
- `overrun`  output  1  sticky; set when column `MAX_COLS+1` completes, cleared by the next `sync` or `reset`.

## Operation
- States: IDLE (no frame open), COLLECT (frame open). Bit index `idx` ranges 0..2. `first` is a flag marking that the next emitted column is the first of its frame.
- Reset state: IDLE, `idx`=0, `first`=0. Outputs: `bits`=000, `bits_valid`=0, `restart`=0, `col_count`=0, `overrun`=0.
- IDLE: samples with `sync`=0 are discarded. On `sin_valid`&`sync`: shift reg bit 2 ← `sin`, `idx`←1, `first`←1, `col_count`←0, `overrun`←0, go to COLLECT.
- COLLECT, `sin_valid`&~`sync`:
  - Store `sin` at position 2−`idx`.
  - If `idx`=2, the column completes:
    - `bits` ← assembled value and `bits_valid`←1.
    - `restart`←`first`, then `first`←0.
    - `col_count`←`col_count`+1, saturating at `MAX_COLS+1`.
    - If the new count is `MAX_COLS+1`, `overrun`←1.
    - `idx`←0.
  - Otherwise `idx`←`idx`+1.
- COLLECT, `sin_valid`&`sync`: any partial column is discarded without emission. The behaviour is identical to the IDLE+`sync` case, so the new frame starts immediately.
- COLLECT, `sin_valid`=0: no state change; gaps of any length between bits are legal, including gaps mid-column.
- Columns keep being emitted after overrun; only the flag and the saturated count reflect the overrun. The block never returns to IDLE except by `reset`.
- `sync` with `sin_valid`=0 is ignored.

## Timing
- All outputs are registered. `bits`, `bits_valid` and `restart` load on the same edge that samples the third bit of a column, and are visible the following cycle.
- Latency from the third bit's sample edge to the strobe is 0 edges; from the first bit's sample edge it is 2 valid-bit edges.
- `bits_valid` and `restart` deassert on the next edge unconditionally.
- Maximum throughput is one column per 3 cycles. Back-to-back frames are legal: `sync` may arrive on the cycle directly after a completing bit.
- `reset` overrides everything. Reset asserted mid-column drops the partial column, and no strobe fires on or after the reset edge.
- `restart` is never high while `bits_valid` is low.

## Test plan
- Reset: hold `reset` 2 cycles with random `sin`/`sin_valid`/`sync` → all outputs 0 and state IDLE; then bits 1,0,0 with no `sync` → no `bits_valid`.
- Basic frame: `sync`+1, 1, 1, then 1, 0, 0, then 0, 0, 0 (continuous valid) → three strobes with `bits`=111, 100, 000; `restart` high only on the first; `col_count`=3.
- Gapped input: same first column with 0–4 idle cycles inserted between bits → `bits`=111 with `restart`=1, exactly one strobe, and it lands on the cycle after the third valid bit.
- Mid-column resync: `sync`+1, 0, then `sync`+0, 1, 1 → only one strobe, `bits`=011, `restart`=1, `col_count`=1.
- Overrun with `MAX_COLS`=8: 9 columns in one frame → `overrun` rises with the 9th strobe and `col_count`=9; a 10th column leaves `col_count`=9; the next `sync` clears `overrun` and sets `col_count`=0.
- Reset mid-operation: assert `reset` after 2 bits of column 2 → no strobe and outputs 0; a fresh `sync` frame then behaves as in the basic-frame scenario.

Source files
------------

// File: rtl/col_framer.sv
// col_framer: assembles a qualified serial stream into 3-bit MSB-first columns,
// marking the first column of each frame and flagging frames with too many columns.
module col_framer #(
  parameter int MAX_COLS = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [2:0]       bits,
  output logic             bits_valid,
  output logic             restart,
  output logic [CNT_W-1:0] col_count,
  output logic             overrun
);
  typedef enum logic {IDLE, COLLECT} state_t;
  localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_COLS + 1);
  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [1:0]       sh, sh_n;
  logic             first, first_n;
  logic [2:0]       bits_n;
  logic             bv_n, rs_n, ov_n;
  logic [CNT_W-1:0] cnt_n, cnt_inc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      sh         <= 2'd0;
      first      <= 1'b0;
      bits       <= 3'd0;
      bits_valid <= 1'b0;
      restart    <= 1'b0;
      col_count  <= '0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      sh         <= sh_n;
      first      <= first_n;
      bits       <= bits_n;
      bits_valid <= bv_n;
      restart    <= rs_n;
      col_count  <= cnt_n;
      overrun    <= ov_n;
    end
  end
  // sh holds the first two bits of the column; the third comes straight from sin
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sh_n    = sh;
    first_n = first;
    bits_n  = bits;
    bv_n    = 1'b0;
    rs_n    = 1'b0;
    cnt_n   = col_count;
    ov_n    = overrun;
    cnt_inc = (col_count == SAT) ? SAT : col_count + 1'b1;
    if (sin_valid && sync) begin
      state_n = COLLECT;
      sh_n    = {sin, 1'b0};
      idx_n   = 2'd1;
      first_n = 1'b1;
      cnt_n   = '0;
      ov_n    = 1'b0;
    end else if (sin_valid && state == COLLECT) begin
      if (idx == 2'd2) begin
        bits_n  = {sh, sin};
        bv_n    = 1'b1;
        rs_n    = first;
        first_n = 1'b0;
        cnt_n   = cnt_inc;
        ov_n    = overrun | (cnt_inc == SAT);
        idx_n   = 2'd0;
      end else begin
        sh_n  = (idx == 2'd0) ? {sin, sh[0]} : {sh[1], sin};
        idx_n = idx + 2'd1;
      end
    end
  end
endmodule
